// File: rtl/parking_occupancy_counter_if.sv
// Sensor, count, pulse and seven-segment bundle
// master drives a/b; slave (counter) drives the rest
interface parking_occupancy_counter_if #(
  parameter int WIDTH = 5
);
  logic             a;
  logic             b;
  logic [WIDTH-1:0] occupancy;
  logic             enter;
  logic             exit;
  logic [6:0]       hex0;
  logic [6:0]       hex1;
  logic [6:0]       hex2;
  logic [6:0]       hex3;
  logic [6:0]       hex4;
  logic [6:0]       hex5;

  modport master (
    output a, b,
    input  occupancy, enter, exit,
    input  hex0, hex1, hex2, hex3, hex4, hex5
  );

  modport slave (
    input  a, b,
    output occupancy, enter, exit,
    output hex0, hex1, hex2, hex3, hex4, hex5
  );
endinterface

// File: rtl/parking_occupancy_counter.sv
// Gate car counter: a/b beam FSM, saturating count, 6-digit display.
// Ports: clk, reset (async low), bus (slave). Option: POC_INPUT_SYNC_EN.
module parking_occupancy_counter #(
  parameter int CAPACITY = 25,
  parameter int WIDTH    = 5
) (
  input logic                      clk,
  input logic                      reset,
  parking_occupancy_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);

  localparam logic [6:0] SEG_BL = 7'b1111111;
  localparam logic [6:0] SEG_C  = 7'b1000110;
  localparam logic [6:0] SEG_L  = 7'b1000111;
  localparam logic [6:0] SEG_E  = 7'b0000110;
  localparam logic [6:0] SEG_A  = 7'b0001000;
  localparam logic [6:0] SEG_R  = 7'b0101111;
  localparam logic [6:0] SEG_F  = 7'b0001110;
  localparam logic [6:0] SEG_U  = 7'b1000001;

  typedef enum logic [2:0] {
    S_IDLE, S_E1, S_E2, S_E3,
    S_X1, S_X2, S_X3, S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic             enter_q, enter_d;
  logic             exit_q, exit_d;
  logic [WIDTH-1:0] occ_q;
  logic [1:0]       ab;

`ifdef POC_INPUT_SYNC_EN
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {bus.a, bus.b};
      sync2_q <= sync1_q;
    end
  end

  assign ab = sync2_q;
`else
  assign ab = {bus.a, bus.b};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
    end
  end

  // Each passage state: hold on its own code,
  // advance on the next, step back on the
  // previous; 00 aborts, anything else -> WAIT.
  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    unique case (state_q)
      S_IDLE:
        case (ab)
          2'b10:   state_d = S_E1;
          2'b01:   state_d = S_X1;
          2'b11:   state_d = S_WAIT;
          default: state_d = S_IDLE;
        endcase
      S_E1:
        case (ab)
          2'b10:   state_d = S_E1;
          2'b11:   state_d = S_E2;
          2'b00:   state_d = S_IDLE;
          default: state_d = S_WAIT;
        endcase
      S_E2:
        case (ab)
          2'b11:   state_d = S_E2;
          2'b01:   state_d = S_E3;
          2'b10:   state_d = S_E1;
          default: state_d = S_IDLE;
        endcase
      S_E3:
        case (ab)
          2'b01:   state_d = S_E3;
          2'b11:   state_d = S_E2;
          2'b00: begin
            state_d = S_IDLE;
            enter_d = 1'b1;
          end
          default: state_d = S_WAIT;
        endcase
      S_X1:
        case (ab)
          2'b01:   state_d = S_X1;
          2'b11:   state_d = S_X2;
          2'b00:   state_d = S_IDLE;
          default: state_d = S_WAIT;
        endcase
      S_X2:
        case (ab)
          2'b11:   state_d = S_X2;
          2'b10:   state_d = S_X3;
          2'b01:   state_d = S_X1;
          default: state_d = S_IDLE;
        endcase
      S_X3:
        case (ab)
          2'b10:   state_d = S_X3;
          2'b11:   state_d = S_X2;
          2'b00: begin
            state_d = S_IDLE;
            exit_d  = 1'b1;
          end
          default: state_d = S_WAIT;
        endcase
      S_WAIT:
        if (ab == 2'b00) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Simultaneous enter/exit cancels out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else if (enter_q && !exit_q) begin
      if (occ_q < CAP) occ_q <= occ_q + 1'b1;
    end else if (exit_q && !enter_q) begin
      if (occ_q != '0) occ_q <= occ_q - 1'b1;
    end
  end

  function automatic logic [6:0] seg(
    input logic [3:0] d
  );
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BL;
    endcase
  endfunction

  logic [31:0] occ_w;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic        is_zero;
  logic        is_full;

  assign occ_w   = 32'(occ_q);
  assign tens    = 4'(occ_w / 32'd10);
  assign ones    = 4'(occ_w % 32'd10);
  assign is_zero = (occ_q == '0);
  assign is_full = (occ_q == CAP);

  always_comb begin
    bus.hex0 = seg(ones);
    bus.hex1 = SEG_BL;
    bus.hex2 = SEG_BL;
    bus.hex3 = SEG_BL;
    bus.hex4 = SEG_BL;
    bus.hex5 = SEG_BL;
    unique case (1'b1)
      is_zero: begin
        bus.hex5 = SEG_C;
        bus.hex4 = SEG_L;
        bus.hex3 = SEG_E;
        bus.hex2 = SEG_A;
        bus.hex1 = SEG_R;
        bus.hex0 = seg(4'd0);
      end
      is_full: begin
        bus.hex5 = SEG_F;
        bus.hex4 = SEG_U;
        bus.hex3 = SEG_L;
        bus.hex2 = SEG_L;
        bus.hex1 = seg(tens);
      end
      default: begin
        if (tens != 4'd0) bus.hex1 = seg(tens);
      end
    endcase
  end

  assign bus.occupancy = occ_q;
  assign bus.enter     = enter_q;
  assign bus.exit      = exit_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Bench for parking_occupancy_counter.
// Scoreboard of expected enter/exit pulses.
module tb_parking_occupancy_counter;

  localparam int CAP = 25;
  localparam int W   = 5;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GL = 7'b1000111;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GR = 7'b0101111;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] GU = 7'b1000001;

  localparam logic [41:0] CLEAR0 =
    {GC, GL, GE, GA, GR, D0};
  localparam logic [41:0] FULL25 =
    {GF, GU, GL, GL, D2, D5};

  typedef struct {
    bit is_enter;
    int occ;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_occ = 0;
  ev_t  sb[$];
  bit   pending = 1'b0;
  int   pend_occ = 0;

  parking_occupancy_counter_if #(.WIDTH(W)) bus ();

  parking_occupancy_counter #(
    .CAPACITY(CAP),
    .WIDTH   (W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [41:0] disp();
    return {bus.hex5, bus.hex4, bus.hex3,
            bus.hex2, bus.hex1, bus.hex0};
  endfunction

  task automatic drive(input logic [1:0] v);
    @(negedge clk);
    bus.a = v[1];
    bus.b = v[0];
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'b00);
  endtask

  task automatic push(input bit is_enter);
    ev_t e;
    if (is_enter) begin
      if (exp_occ < CAP) exp_occ++;
    end else begin
      if (exp_occ > 0) exp_occ--;
    end
    e.is_enter = is_enter;
    e.occ      = exp_occ;
    sb.push_back(e);
  endtask

  task automatic entry();
    push(1'b1);
    drive(2'b10);
    drive(2'b11);
    drive(2'b01);
    drive(2'b00);
    idle(2);
  endtask

  task automatic leave();
    push(1'b0);
    drive(2'b01);
    drive(2'b11);
    drive(2'b10);
    drive(2'b00);
    idle(2);
  endtask

  // Pulse monitor: pops the scoreboard,
  // then checks the count one edge later.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (pending) begin
        check("occ_upd",
              64'(bus.occupancy), 64'(pend_occ));
        pending = 1'b0;
      end
      if (bus.enter || bus.exit) begin
        if (sb.size() == 0) begin
          check("unexp_pulse",
                64'({bus.enter, bus.exit}), 64'(0));
        end else begin
          e = sb.pop_front();
          check("pulse_kind",
                64'({bus.enter, bus.exit}),
                e.is_enter ? 64'(2) : 64'(1));
          pending  = 1'b1;
          pend_occ = e.occ;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.a = 1'b0;
    bus.b = 1'b0;
    #3;
    check("rst_occ", 64'(bus.occupancy), 64'(0));
    check("rst_enter", 64'(bus.enter), 64'(0));
    check("rst_exit", 64'(bus.exit), 64'(0));
    check("rst_disp", 64'(disp()), 64'(CLEAR0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    idle(1);
    entry();
    check("one_occ", 64'(bus.occupancy), 64'(1));
    check("one_disp", 64'(disp()),
          64'({BL, BL, BL, BL, BL, D1}));

    idle(1);
    leave();
    check("zero_occ", 64'(bus.occupancy), 64'(0));
    check("zero_disp", 64'(disp()), 64'(CLEAR0));

    push(1'b1);
    drive(2'b10);
    drive(2'b11);
    drive(2'b10);
    drive(2'b11);
    drive(2'b01);
    drive(2'b00);
    idle(2);
    check("back_occ", 64'(bus.occupancy), 64'(1));

    drive(2'b10);
    drive(2'b01);
    drive(2'b00);
    idle(3);
    check("illegal_occ",
          64'(bus.occupancy), 64'(1));

    push(1'b1);
    drive(2'b10);
    drive(2'b10);
    drive(2'b11);
    drive(2'b11);
    drive(2'b01);
    drive(2'b01);
    drive(2'b00);
    idle(2);
    check("hold_occ", 64'(bus.occupancy), 64'(2));

    while (exp_occ < CAP) begin
      entry();
      if (exp_occ == 10)
        check("disp10", 64'(disp()),
              64'({BL, BL, BL, BL, D1, D0}));
      if (exp_occ == 13)
        check("disp13", 64'(disp()),
              64'({BL, BL, BL, BL, D1, D3}));
    end
    check("full_occ", 64'(bus.occupancy), 64'(CAP));
    check("full_disp", 64'(disp()), 64'(FULL25));

    entry();
    check("sat_occ", 64'(bus.occupancy), 64'(CAP));
    check("sat_disp", 64'(disp()), 64'(FULL25));

    drive(2'b10);
    drive(2'b11);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_occ = 0;
    check("mid_rst_occ",
          64'(bus.occupancy), 64'(0));
    check("mid_rst_enter",
          64'(bus.enter), 64'(0));
    check("mid_rst_disp", 64'(disp()), 64'(CLEAR0));
    @(negedge clk);
    reset = 1'b1;
    drive(2'b01);
    idle(3);
    check("post_rst_occ",
          64'(bus.occupancy), 64'(0));

    leave();
    check("under_occ", 64'(bus.occupancy), 64'(0));
    check("under_disp", 64'(disp()), 64'(CLEAR0));

    idle(3);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
